// File: rtl/matmul_pkg.sv
// Shared constants for the matmul register file: word map, CTRL/STATUS bit
// positions, FSM encoding and decoded-region type.
package matmul_pkg;

    localparam int unsigned W_CTRL   = 0;
    localparam int unsigned W_STATUS = 1;
    localparam int unsigned W_A_BASE = 4;
    localparam int unsigned W_B_BASE = 8;
    localparam int unsigned W_C_BASE = 12;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned STATUS_DONE_BIT = 0;
    localparam int unsigned STATUS_BUSY_BIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        RGN_NONE   = 3'd0,
        RGN_CTRL   = 3'd1,
        RGN_STATUS = 3'd2,
        RGN_A      = 3'd3,
        RGN_B      = 3'd4,
        RGN_C      = 3'd5
    } region_e;

endpackage

// File: rtl/matmul_regfile_decode.sv
// Combinational address decode: maps a byte address onto a register region,
// a row within that region, and an alignment flag.
module matmul_regfile_decode
    import matmul_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 64,
    parameter int unsigned MAX_DIM    = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output region_e               region_c,
    output logic [1:0]            row_c,
    output logic                  aligned_c
);

    localparam int unsigned OFS_BITS = $clog2(BUS_WIDTH / 8);
    localparam int unsigned WIDX_W   = ADDR_WIDTH - OFS_BITS;

    logic [WIDX_W-1:0] widx;
    logic              hi_zero;
    logic [4:0]        lo5;

    assign widx      = addr[ADDR_WIDTH-1:OFS_BITS];
    assign aligned_c = (addr[OFS_BITS-1:0] == '0);
    // Every mapped word lives below 16, so only the low nibble needs a real compare.
    assign hi_zero   = (widx[WIDX_W-1:4] == '0);
    assign lo5       = {1'b0, widx[3:0]};

    always_comb begin
        region_c = RGN_NONE;
        row_c    = '0;
        if (hi_zero) begin
            if (lo5 == 5'(W_CTRL)) begin
                region_c = RGN_CTRL;
            end else if (lo5 == 5'(W_STATUS)) begin
                region_c = RGN_STATUS;
            end else if (lo5 >= 5'(W_A_BASE) && lo5 < 5'(W_A_BASE + MAX_DIM)) begin
                region_c = RGN_A;
                row_c    = 2'(lo5 - 5'(W_A_BASE));
            end else if (lo5 >= 5'(W_B_BASE) && lo5 < 5'(W_B_BASE + MAX_DIM)) begin
                region_c = RGN_B;
                row_c    = 2'(lo5 - 5'(W_B_BASE));
            end else if (lo5 >= 5'(W_C_BASE) && lo5 < 5'(W_C_BASE + MAX_DIM)) begin
                region_c = RGN_C;
                row_c    = 2'(lo5 - 5'(W_C_BASE));
            end
        end
    end

endmodule

// File: rtl/matmul_regfile.sv
// Register/operand buffer for the matmul accelerator: A/B/C row storage,
// CTRL/STATUS, start/done tracking. Optional irq via MATMUL_REGFILE_IRQ_EN.
module matmul_regfile
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic                         rd_en_i,
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    input  logic [BUS_WIDTH-1:0]         wdata_i,
    input  logic [MAX_DIM-1:0]           strb_i,
    output logic                         ack_o,
    output logic                         err_o,
    output logic [BUS_WIDTH-1:0]         rdata_o,
    output logic                         start_o,
    input  logic                         done_i,
    output logic [MAX_DIM*BUS_WIDTH-1:0] a_flat_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0] b_flat_o,
    input  logic                         c_we_i,
    input  logic [1:0]                   c_row_i,
    input  logic [BUS_WIDTH-1:0]         c_data_i,
    output logic                         irq_o
);

    state_e                             state_q;
    logic                               done_q;
    logic                               irq_en_q;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  a_q;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  b_q;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  c_q;

    region_e                            region_c;
    logic [1:0]                         row_c;
    logic                               aligned_c;

    logic                               req_c;
    logic                               bad_c;
    logic                               wr_ok_c;
    logic                               rd_ok_c;
    logic                               start_c;
    logic                               done_set_c;
    logic                               done_clr_c;
    logic                               done_nxt_c;
    logic [BUS_WIDTH-1:0]               rd_word_c;

    matmul_regfile_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .MAX_DIM    (MAX_DIM)
    ) u_decode (
        .addr      (addr_i),
        .region_c  (region_c),
        .row_c     (row_c),
        .aligned_c (aligned_c)
    );

    assign a_flat_o = a_q;
    assign b_flat_o = b_q;

    // Access legality and the resulting control strobes.
    always_comb begin
        req_c = wr_en_i | rd_en_i;
        bad_c = 1'b0;
        if (wr_en_i && rd_en_i) begin
            bad_c = 1'b1;
        end else if (!aligned_c || region_c == RGN_NONE) begin
            bad_c = 1'b1;
        end else if (wr_en_i) begin
            case (region_c)
                RGN_C:                  bad_c = 1'b1;
                RGN_A, RGN_B, RGN_CTRL: bad_c = (state_q == ST_RUN);
                default:                bad_c = 1'b0;
            endcase
        end
        wr_ok_c    = wr_en_i & ~bad_c;
        rd_ok_c    = rd_en_i & ~bad_c;
        start_c    = wr_ok_c && region_c == RGN_CTRL && wdata_i[CTRL_START_BIT];
        done_clr_c = wr_ok_c && region_c == RGN_STATUS && wdata_i[STATUS_DONE_BIT];
        done_set_c = (state_q == ST_RUN) && done_i;
        // A completion on the same edge as a clear must win.
        done_nxt_c = done_set_c | (done_q & ~done_clr_c);
    end

    // Read mux; reflects register contents before this edge's updates.
    always_comb begin
        rd_word_c = '0;
        case (region_c)
            RGN_CTRL:   rd_word_c[CTRL_IRQ_EN_BIT] = irq_en_q;
            RGN_STATUS: begin
                rd_word_c[STATUS_DONE_BIT] = done_q;
                rd_word_c[STATUS_BUSY_BIT] = (state_q == ST_RUN);
            end
            RGN_A:
                for (int r = 0; r < MAX_DIM; r++)
                    if (row_c == 2'(r)) rd_word_c = a_q[r];
            RGN_B:
                for (int r = 0; r < MAX_DIM; r++)
                    if (row_c == 2'(r)) rd_word_c = b_q[r];
            RGN_C:
                for (int r = 0; r < MAX_DIM; r++)
                    if (row_c == 2'(r)) rd_word_c = c_q[r];
            default:    rd_word_c = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
            start_o <= 1'b0;
        end else begin
            ack_o   <= req_c;
            err_o   <= req_c & bad_c;
            rdata_o <= rd_ok_c ? rd_word_c : '0;
            start_o <= start_c;
            done_q  <= done_nxt_c;

            case (state_q)
                ST_IDLE: if (start_c) state_q <= ST_RUN;
                ST_RUN:  if (done_i)  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            // Element-strobed operand writes.
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int k = 0; k < MAX_DIM; k++) begin
                    if (wr_ok_c && row_c == 2'(r) && strb_i[k]) begin
                        if (region_c == RGN_A)
                            a_q[r][k*DATA_WIDTH +: DATA_WIDTH] <= wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                        if (region_c == RGN_B)
                            b_q[r][k*DATA_WIDTH +: DATA_WIDTH] <= wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (c_we_i && c_row_i == 2'(r))
                    c_q[r] <= c_data_i;
            end
        end
    end

`ifdef MATMUL_REGFILE_IRQ_EN
    logic irq_en_nxt_c;

    assign irq_en_nxt_c = (wr_ok_c && region_c == RGN_CTRL) ? wdata_i[CTRL_IRQ_EN_BIT] : irq_en_q;

    // irq tracks DONE & IRQ_EN as they stand after this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_nxt_c;
            irq_o    <= done_nxt_c & irq_en_nxt_c;
        end
    end
`else
    assign irq_en_q = 1'b0;
    assign irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_regfile.sv
// Self-checking bench for matmul_regfile: directed plan items plus random
// traffic checked against an array-based reference model.
module tb_matmul_regfile;

    localparam int unsigned MD = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic          rd_en_i = 1'b0;
    logic [31:0]   addr_i = '0;
    logic [63:0]   wdata_i = '0;
    logic [1:0]    strb_i = '0;
    logic          ack_o, err_o, start_o, irq_o;
    logic [63:0]   rdata_o;
    logic          done_i = 1'b0;
    logic [127:0]  a_flat_o, b_flat_o;
    logic          c_we_i = 1'b0;
    logic [1:0]    c_row_i = '0;
    logic [63:0]   c_data_i = '0;

    matmul_regfile dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (wr_en_i),
        .rd_en_i  (rd_en_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .strb_i   (strb_i),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .start_o  (start_o),
        .done_i   (done_i),
        .a_flat_o (a_flat_o),
        .b_flat_o (b_flat_o),
        .c_we_i   (c_we_i),
        .c_row_i  (c_row_i),
        .c_data_i (c_data_i),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [63:0] a_m [4];
    logic [63:0] b_m [4];
    logic [63:0] c_m [4];
    logic        run_m, done_m, irq_en_m;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    logic [63:0] obs_rdata;
    logic        obs_err;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 4; r++) begin
            a_m[r] = '0; b_m[r] = '0; c_m[r] = '0;
        end
        run_m = 1'b0; done_m = 1'b0; irq_en_m = 1'b0;
    endtask

    // One clock cycle: drive, predict from the model, update model, compare.
    task automatic step(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [1:0] strb,
                        input logic done, input logic cwe, input logic [1:0] crow,
                        input logic [63:0] cdata, input logic rst);
        logic [31:0]  w;
        logic         is_ctrl, is_stat, is_a, is_b, is_c, mapped, lwr, lrd;
        logic         e_ack, e_err, e_start, e_irq;
        logic [63:0]  e_rdata;
        logic [127:0] e_a, e_b;
        int           row;

        @(negedge clk_i);
        wr_en_i = wr; rd_en_i = rd; addr_i = addr; wdata_i = wdata; strb_i = strb;
        done_i = done; c_we_i = cwe; c_row_i = crow; c_data_i = cdata; rst_i = rst;

        e_ack = 0; e_err = 0; e_rdata = '0; e_start = 0;
        if (rst) begin
            model_clear();
        end else begin
            w       = addr >> 3;
            is_ctrl = (w == 0);
            is_stat = (w == 1);
            is_a    = (w >= 4)  && (w < 4 + MD);
            is_b    = (w >= 8)  && (w < 8 + MD);
            is_c    = (w >= 12) && (w < 12 + MD);
            mapped  = is_ctrl | is_stat | is_a | is_b | is_c;
            row     = int'(w % 4);
            e_ack   = wr | rd;
            e_err   = e_ack && ((wr && rd) || addr[2:0] != 0 || !mapped || (wr && is_c)
                               || (wr && run_m && (is_a || is_b || is_ctrl)));
            lwr = wr && !e_err;
            lrd = rd && !e_err;
            if (lrd) begin
                if (is_ctrl)      e_rdata = {62'b0, irq_en_m, 1'b0};
                else if (is_stat) e_rdata = {62'b0, run_m, done_m};
                else if (is_a)    e_rdata = a_m[row];
                else if (is_b)    e_rdata = b_m[row];
                else              e_rdata = c_m[row];
            end
            e_start = lwr && is_ctrl && wdata[0];
            if (lwr && is_stat && wdata[0]) done_m = 1'b0;
            if (run_m && done) begin
                done_m = 1'b1;
                run_m  = 1'b0;
            end
            if (e_start) run_m = 1'b1;
`ifdef MATMUL_REGFILE_IRQ_EN
            if (lwr && is_ctrl) irq_en_m = wdata[1];
`endif
            for (int k = 0; k < MD; k++) begin
                if (lwr && is_a && strb[k]) a_m[row][k*32 +: 32] = wdata[k*32 +: 32];
                if (lwr && is_b && strb[k]) b_m[row][k*32 +: 32] = wdata[k*32 +: 32];
            end
            if (cwe && crow < MD) c_m[crow] = cdata;
        end
        e_irq = done_m & irq_en_m;
        e_a = '0; e_b = '0;
        for (int r = 0; r < MD; r++) begin
            e_a[r*64 +: 64] = a_m[r];
            e_b[r*64 +: 64] = b_m[r];
        end

        @(posedge clk_i);
        #1;
        check_eq("ack", 128'(ack_o), 128'(e_ack));
        check_eq("err", 128'(err_o), 128'(e_err));
        check_eq("rdata", 128'(rdata_o), 128'(e_rdata));
        check_eq("start", 128'(start_o), 128'(e_start));
        check_eq("irq", 128'(irq_o), 128'(e_irq));
        check_eq("a_flat", a_flat_o, e_a);
        check_eq("b_flat", b_flat_o, e_b);
        obs_rdata = rdata_o;
        obs_err   = err_o;
        wr_en_i = 0; rd_en_i = 0; done_i = 0; c_we_i = 0; rst_i = 0;
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [63:0] d, input logic [1:0] s);
        step(1, 0, addr, d, s, 0, 0, 0, '0, 0);
    endtask

    task automatic rd_word(input logic [31:0] addr);
        step(0, 1, addr, '0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic idle(input logic done);
        step(0, 0, '0, '0, 0, done, 0, 0, '0, 0);
    endtask

    initial begin
        logic [31:0] w, addr;
        logic        wr, rd;
        int          pick;

        model_clear();
        step(0, 0, '0, '0, 0, 0, 0, 0, '0, 1);

        rd_word(32'h8);
        check_eq("plan_status_reset", 128'(obs_rdata), 128'h0);

        wr_word(32'h20, 64'h00000002_00000001, 2'b11);
        wr_word(32'h20, 64'h00000009_FFFFFFFF, 2'b10);
        rd_word(32'h20);
        check_eq("plan_a0_strb", 128'(obs_rdata), 128'h00000009_00000001);

        wr_word(32'h48, 64'h1234_5678_9abc_def0, 2'b11);
        wr_word(32'h0, 64'h1, 2'b00);
        rd_word(32'h8);
        check_eq("plan_busy", 128'(obs_rdata), 128'h2);
        wr_word(32'h48, 64'hdead_beef_dead_beef, 2'b11);
        check_eq("plan_b_run_err", 128'(obs_err), 128'h1);
        rd_word(32'h48);
        check_eq("plan_b_kept", 128'(obs_rdata), 128'h1234_5678_9abc_def0);

        idle(1);
        rd_word(32'h8);
        check_eq("plan_done", 128'(obs_rdata), 128'h1);
        wr_word(32'h8, 64'h1, 2'b00);
        rd_word(32'h8);
        check_eq("plan_done_clr", 128'(obs_rdata), 128'h0);

        wr_word(32'h0, 64'h1, 2'b00);
        idle(1);
        wr_word(32'h0, 64'h1, 2'b00);
        step(1, 0, 32'h8, 64'h1, 2'b00, 1, 0, 0, '0, 0);
        rd_word(32'h8);
        check_eq("plan_set_wins", 128'(obs_rdata), 128'h1);

        rd_word(32'h18);
        step(1, 0, 32'h60, 64'h5, 2'b11, 0, 0, 0, '0, 0);
        rd_word(32'h4);
        step(1, 1, 32'h20, 64'h5, 2'b11, 0, 0, 0, '0, 0);
        check_eq("plan_both_err", 128'(obs_err), 128'h1);

        step(0, 0, '0, '0, 0, 0, 1, 2'd1, 64'hc0ffee, 0);
        step(0, 1, 32'h68, '0, 0, 0, 1, 2'd1, 64'h5555, 0);
        check_eq("plan_c_old", 128'(obs_rdata), 128'hc0ffee);

        wr_word(32'h8, 64'h1, 2'b00);
        wr_word(32'h0, 64'h3, 2'b00);
        idle(1);
        idle(0);
        wr_word(32'h8, 64'h1, 2'b00);
        idle(0);

        wr_word(32'h0, 64'h1, 2'b00);
        step(0, 0, '0, '0, 0, 0, 0, 0, '0, 1);
        idle(1);
        rd_word(32'h8);
        check_eq("plan_rst_done", 128'(obs_rdata), 128'h0);
        rd_word(32'h20);
        check_eq("plan_rst_a", 128'(obs_rdata), 128'h0);
        rd_word(32'h68);
        check_eq("plan_rst_c", 128'(obs_rdata), 128'h0);

        for (int i = 0; i < 4000; i++) begin
            pick = int'($urandom_range(0, 17));
            case (pick)
                0, 1:    w = 0;
                2, 3:    w = 1;
                4, 5:    w = 4 + $urandom_range(0, 1);
                6, 7:    w = 8 + $urandom_range(0, 1);
                8, 9:    w = 12 + $urandom_range(0, 1);
                10:      w = 2 + $urandom_range(0, 1);
                11:      w = 6 + $urandom_range(0, 1);
                12:      w = 10 + $urandom_range(0, 1);
                13:      w = 14 + $urandom_range(0, 1);
                14:      w = 16 + $urandom_range(0, 15);
                15:      w = $urandom;
                default: w = $urandom_range(0, 15);
            endcase
            addr = w << 3;
            if ($urandom_range(0, 15) == 0) addr[2:0] = 3'($urandom_range(1, 7));
            pick = int'($urandom_range(0, 99));
            wr = (pick < 45) || (pick >= 97);
            rd = (pick >= 45 && pick < 90) || (pick >= 97);
            step(wr, rd, addr, {$urandom, $urandom}, 2'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                 2'($urandom), {$urandom, $urandom}, ($urandom_range(0, 499) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
